// File: rtl/fir_sample_serializer.sv
`default_nettype none
// =============================================================================
// Module   : fir_sample_serializer
// Function : FIFO-buffered MSB-first serializer for FIR output samples onto a
//            three-wire link (sclk, frame, data). Define FIR_SER_PARITY_EN to
//            append an even-parity bit after the LSB.
// Revision : 1.0
// =============================================================================
module fir_sample_serializer #(
   parameter int DEPTH      = 4,
   parameter int BIT_CYCLES = 4
) (
   input  logic                   system1000,
   input  logic                   system1000_rstn,
   input  logic signed [15:0]     sample_in,
   input  logic                   sample_valid,
   output logic                   sample_ready,
   output logic                   ser_sclk,
   output logic                   ser_frame,
   output logic                   ser_data,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_level
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_lw = c_aw + 1;
`ifdef FIR_SER_PARITY_EN
   localparam int c_nbits = 17;
`else
   localparam int c_nbits = 16;
`endif
   localparam int c_bw = $clog2(c_nbits);
   localparam int c_dw = $clog2(BIT_CYCLES);

   localparam logic [c_lw-1:0] c_full     = c_lw'(DEPTH);
   localparam logic [c_bw-1:0] c_bit_msb  = c_bw'(c_nbits - 1);
   localparam logic [c_dw-1:0] c_div_last = c_dw'(BIT_CYCLES - 1);
   localparam logic [c_dw-1:0] c_div_half = c_dw'(BIT_CYCLES / 2);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   logic [15:0]        r_mem [DEPTH];
   logic [c_aw-1:0]    r_wr_ptr;
   logic [c_aw-1:0]    r_rd_ptr;
   logic [c_lw-1:0]    r_level;

   state_t             r_state;
   state_t             w_state_n;
   logic [c_dw-1:0]    r_div;
   logic [c_dw-1:0]    w_div_n;
   logic [c_bw-1:0]    r_bit;
   logic [c_bw-1:0]    w_bit_n;
   logic [c_nbits-1:0] r_shreg;
   logic [c_nbits-1:0] w_shreg_n;
   logic [c_nbits-1:0] w_load;

   logic               w_push;
   logic               w_pop;
   logic               w_not_empty;
   logic [15:0]        w_head;

   // Ready depends only on the registered level, so a same-cycle pop never
   // makes room for a push into a full FIFO.
   assign sample_ready = (r_level != c_full);
   assign fifo_level   = r_level;
   assign busy         = (r_state == SHIFT);
   assign w_push       = sample_valid && sample_ready;
   assign w_not_empty  = (r_level != '0);
   assign w_head       = r_mem[r_rd_ptr];

`ifdef FIR_SER_PARITY_EN
   assign w_load = {w_head, ^w_head};
`else
   assign w_load = w_head;
`endif

   always_ff @(posedge system1000) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= sample_in;
      end
   end

   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_comb begin
      w_pop     = 1'b0;
      w_state_n = r_state;
      w_div_n   = r_div;
      w_bit_n   = r_bit;
      w_shreg_n = r_shreg;
      case (r_state)
         IDLE: begin
            if (w_not_empty) begin
               w_pop     = 1'b1;
               w_state_n = SHIFT;
               w_div_n   = '0;
               w_bit_n   = c_bit_msb;
               w_shreg_n = w_load;
            end
         end
         SHIFT: begin
            if (r_div == c_div_last) begin
               w_div_n = '0;
               if (r_bit == '0) begin
                  // Frame boundary: reload directly so frames run back to back.
                  if (w_not_empty) begin
                     w_pop     = 1'b1;
                     w_bit_n   = c_bit_msb;
                     w_shreg_n = w_load;
                  end else begin
                     w_state_n = IDLE;
                  end
               end else begin
                  w_bit_n   = r_bit - 1'b1;
                  w_shreg_n = {r_shreg[c_nbits-2:0], 1'b0};
               end
            end else begin
               w_div_n = r_div + 1'b1;
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge system1000 or negedge system1000_rstn) begin
      if (!system1000_rstn) begin
         r_state   <= IDLE;
         r_div     <= '0;
         r_bit     <= '0;
         r_shreg   <= '0;
         ser_sclk  <= 1'b0;
         ser_frame <= 1'b0;
         ser_data  <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_div     <= w_div_n;
         r_bit     <= w_bit_n;
         r_shreg   <= w_shreg_n;
         // Line outputs are registered from next-state values so they stay
         // aligned with the state registers updated on the same edge.
         ser_data  <= (w_state_n == SHIFT) && w_shreg_n[c_nbits-1];
         ser_frame <= (w_state_n == SHIFT) && (w_bit_n == c_bit_msb);
         ser_sclk  <= (w_state_n == SHIFT) && (w_div_n >= c_div_half);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_serializer.sv
`default_nettype none
// =============================================================================
// Module   : tb_fir_sample_serializer
// Function : Self-checking bench: directed vector table, burst/full/reset
//            sequences and a random stream against a serial-receiver scoreboard.
// Revision : 1.0
// =============================================================================
module tb_fir_sample_serializer;

   localparam int DEPTH      = 4;
   localparam int BIT_CYCLES = 4;
`ifdef FIR_SER_PARITY_EN
   localparam int NBITS = 17;
`else
   localparam int NBITS = 16;
`endif
   localparam int FRAME = NBITS * BIT_CYCLES;

   logic                   clk          = 1'b0;
   logic                   rst_n        = 1'b0;
   logic signed [15:0]     sample_in    = '0;
   logic                   sample_valid = 1'b0;
   logic                   sample_ready;
   logic                   ser_sclk;
   logic                   ser_frame;
   logic                   ser_data;
   logic                   busy;
   logic [$clog2(DEPTH):0] fifo_level;

   always #5 clk = ~clk;

   fir_sample_serializer #(
      .DEPTH      (DEPTH),
      .BIT_CYCLES (BIT_CYCLES)
   ) dut (
      .system1000      (clk),
      .system1000_rstn (rst_n),
      .sample_in       (sample_in),
      .sample_valid    (sample_valid),
      .sample_ready    (sample_ready),
      .ser_sclk        (ser_sclk),
      .ser_frame       (ser_frame),
      .ser_data        (ser_data),
      .busy            (busy),
      .fifo_level      (fifo_level)
   );

   typedef struct packed {
      logic [15:0] sample;
      logic        par;
   } vec_t;

   vec_t             vecs [11];
   logic [15:0]      burst [5];
   int               checks       = 0;
   int               errors       = 0;
   logic [15:0]      sb_q [$];
   int               mon_cnt      = -1;
   logic             mon_prev     = 1'b0;
   logic [NBITS-1:0] mon_word     = '0;
   logic [NBITS-1:0] mon_last     = '0;
   int               mon_frames   = 0;
   int               busy_cycles  = 0;
   int               frame_cycles = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [NBITS-1:0] expected_word(input logic [15:0] s);
`ifdef FIR_SER_PARITY_EN
      return {s, ^s};
`else
      return s;
`endif
   endfunction

   // Link receiver: samples data on sclk rising edges, frame marks the MSB.
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_cnt  = -1;
         mon_prev = 1'b0;
      end else begin
         if (busy) busy_cycles++;
         if (ser_frame) frame_cycles++;
         if (ser_sclk && !mon_prev) begin
            if (ser_frame) begin
               check("frame_align", mon_cnt, -1);
               mon_cnt  = 0;
               mon_word = '0;
            end
            if (mon_cnt >= 0) begin
               mon_word = {mon_word[NBITS-2:0], ser_data};
               mon_cnt++;
               if (mon_cnt == NBITS) begin
                  mon_last = mon_word;
                  mon_frames++;
                  if (sb_q.size() == 0) check("sb_underflow", 1, 0);
                  else check("serial_word", mon_word, expected_word(sb_q.pop_front()));
                  mon_cnt = -1;
               end
            end
         end
         mon_prev = ser_sclk;
      end
   end

   task automatic do_reset();
      sample_valid = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic push_one(input logic [15:0] s);
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in    = s;
      check("ready_on_push", sample_ready, 1);
      if (sample_ready) sb_q.push_back(s);
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", 1, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fr0;
      int n;
      int acc;

      vecs[0]  = '{16'h8001, 1'b0};
      vecs[1]  = '{16'h0007, 1'b1};
      vecs[2]  = '{16'h0003, 1'b0};
      vecs[3]  = '{16'h0001, 1'b1};
      vecs[4]  = '{16'hFFFF, 1'b0};
      vecs[5]  = '{16'h7FFF, 1'b1};
      vecs[6]  = '{16'h0000, 1'b0};
      vecs[7]  = '{16'h1234, 1'b1};
      vecs[8]  = '{16'h00FF, 1'b0};
      vecs[9]  = '{16'hA5C3, 1'b0};
      vecs[10] = '{16'h8000, 1'b1};
      burst    = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h5A5A};

      do_reset();
      @(negedge clk);
      check("rst_level", fifo_level, 0);
      check("rst_ready", sample_ready, 1);
      check("rst_lines", {ser_sclk, ser_frame, ser_data}, 0);
      check("rst_busy", busy, 0);

      // Single frames from the vector table.
      for (int i = 0; i < 11; i++) begin
         busy_cycles  = 0;
         frame_cycles = 0;
         fr0 = mon_frames;
         push_one(vecs[i].sample);
         @(negedge clk);
         check("msb_latency", ser_data, vecs[i].sample[15]);
         check("frame_first", ser_frame, 1);
         check("busy_first", busy, 1);
         wait_idle(FRAME + 10);
         check("busy_len", busy_cycles, FRAME);
         check("frame_len", frame_cycles, BIT_CYCLES);
         check("frames_rx", mon_frames - fr0, 1);
         check("rx_data_parity", ^mon_last[NBITS-1 -: 16], vecs[i].par);
`ifdef FIR_SER_PARITY_EN
         check("parity_bit", mon_last[0], vecs[i].par);
`endif
         check("idle_lines", {ser_sclk, ser_frame, ser_data}, 0);
      end

      // Burst fill, then a blocked push across the frame-boundary pop.
      busy_cycles = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 4) check("level_after_four", fifo_level, DEPTH - 1);
         sample_valid = 1'b1;
         sample_in    = burst[i];
         check("burst_ready", sample_ready, 1);
         if (sample_ready) sb_q.push_back(burst[i]);
      end
      @(negedge clk);
      check("full_level", fifo_level, DEPTH);
      check("full_ready", sample_ready, 0);
      sample_in = 16'hDEAD;
      n = 0;
      while (!sample_ready && n < 2 * FRAME) begin
         @(negedge clk);
         n++;
      end
      check("pop_timing", n, FRAME - 3);
      check("level_after_pop", fifo_level, DEPTH - 1);
      check("ready_after_pop", sample_ready, 1);
      sample_valid = 1'b0;
      wait_idle(6 * FRAME);
      check("burst_contiguous", busy_cycles, 5 * FRAME);
      check("burst_level_end", fifo_level, 0);
      check("burst_sb_empty", sb_q.size(), 0);

      // Reset in the middle of a frame with another sample buffered.
      push_one(16'h1234);
      push_one(16'hAAAA);
      repeat (20) @(negedge clk);
      check("pre_reset_busy", busy, 1);
      check("pre_reset_level", fifo_level, 1);
      rst_n = 1'b0;
      #1;
      check("abort_lines", {ser_sclk, ser_frame, ser_data}, 0);
      check("abort_busy", busy, 0);
      check("abort_level", fifo_level, 0);
      check("abort_ready", sample_ready, 1);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("discarded_idle", busy, 0);
      busy_cycles = 0;
      fr0 = mon_frames;
      push_one(16'h00FF);
      @(negedge clk);
      wait_idle(FRAME + 10);
      check("post_reset_frames", mon_frames - fr0, 1);
      check("post_reset_len", busy_cycles, FRAME);
      check("post_reset_sb", sb_q.size(), 0);

      // Random valid pattern, 1000 accepted samples.
      fr0 = mon_frames;
      acc = 0;
      n = 0;
      while (acc < 1000 && n < 90000) begin
         @(negedge clk);
         n++;
         sample_valid = ($urandom_range(0, 3) != 0);
         sample_in    = 16'($urandom);
         if (sample_valid && sample_ready) begin
            sb_q.push_back(sample_in);
            acc++;
         end
      end
      @(negedge clk);
      sample_valid = 1'b0;
      check("rand_accepted", acc, 1000);
      n = 0;
      while ((sb_q.size() != 0 || busy) && n < (DEPTH + 2) * FRAME) begin
         @(negedge clk);
         n++;
      end
      check("rand_sb_empty", sb_q.size(), 0);
      check("rand_frames", mon_frames - fr0, 1000);
      check("rand_level_end", fifo_level, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
